peripheral_bus_controller: RTL and testbench
============================================

# peripheral_bus_controller

Memory-mapped controller between the CPU load/store port and the board peripherals: the 32-bit signed keypad value and the 32-bit signed display input. Qualifies keypad value changes with a stability counter, buffers committed entries in a small FIFO for CPU reads, and selects which source drives the display. Sits between the CPU data bus decode and the keypad/display peripherals in the top level.

## Interface
- FIFO_DEPTH, 4, keypad entry FIFO depth; power of two, 2..16
- STABLE_CYCLES, 16, consecutive clk cycles a new keypad value must hold before commit; ≥1
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- addr  in  2  word register select: 0 DISP, 1 KPDATA, 2 STATUS, 3 CTRL
- wr_en  in  1  write strobe, single cycle
- rd_en  in  1  read strobe, single cycle
- wdata  in  32  write data
- rdata  out  32  read data, registered
- rdata_valid  out  1  high one cycle when rdata carries a read result
- kp_value  in  32  signed keypad value, synchronous to clk
- disp_din  out  32  signed value to the display peripheral, registered

## Operation
- Registers:
  - DISP (RW): 32-bit display value.
  - KPDATA (R): pops the FIFO head. Writes are ignored.
  - STATUS (R): bit0 empty, bit1 full, bit2 overflow (sticky), bits[12:8] entry count, all other bits 0. Any write clears overflow.
  - CTRL (RW): bit0 echo mode; other bits read 0.
- Change detector, states TRACK and QUALIFY; registers committed, candidate, count.
  - TRACK: kp_value == committed → stay. Otherwise candidate ← kp_value, count ← 1, go to QUALIFY.
  - QUALIFY: kp_value == committed → count ← 0, go to TRACK. kp_value == candidate → count ← count+1. Any other value → candidate ← kp_value, count ← 1.
  - When count would reach STABLE_CYCLES: committed ← candidate, push candidate, go to TRACK.
  - With STABLE_CYCLES=1, commit happens on the first differing cycle.
- FIFO:
  - Push while full (and no same-cycle pop): entry dropped, overflow ← 1.
  - Pop while empty: rdata = 0, rdata_valid still pulses, no state change.
  - Simultaneous push and pop:
    - Full: pop then push; count unchanged, no overflow.
    - Empty: read returns 0 and the pushed entry is stored.
  - Pointers wrap modulo FIFO_DEPTH.
- Bus:
  - wr_en and rd_en both high: write performed, read ignored, rdata_valid stays low.
  - Read of DISP/STATUS/CTRL has no side effects.
- Display source:
  - disp_din ← DISP when echo mode = 0, ← committed when echo mode = 1.
  - DISP writes in echo mode update DISP but are not shown until echo mode clears.

## Timing
- Reset (rst_n low at posedge): rdata 0, rdata_valid 0, disp_din 0, DISP 0, CTRL 0, FIFO empty, overflow 0, committed 0, candidate 0, count 0, state TRACK.
  - A kp_value of 0 after reset is never pushed.
  - Reset mid-QUALIFY discards the candidate.
- Read latency 1: rd_en at edge N → rdata/rdata_valid at edge N+1. STATUS reflects state before any same-edge push/pop.
- Write visible at edge N+1. disp_din updates one cycle after the DISP/CTRL register change (2 cycles from wr_en).
- Keypad change stable from cycle K: commit/push at edge K+STABLE_CYCLES−1 relative to first sample. Visible in STATUS/KPDATA on the following read. disp_din in echo mode follows one cycle after commit.

## Configuration
- KP_ECHO_EN defined: CTRL bit0 implemented as above.
- KP_ECHO_EN undefined: CTRL bit0 reads 0, writes ignored, disp_din always follows DISP. The committed→display path is not built.

## Test plan
- Reset, then read STATUS → rdata 0x0000_0001 (empty) with rdata_valid one cycle after rd_en; disp_din 0.
- Write DISP=0x7FFF_FFF0 → disp_din 0x7FFF_FFF0 two cycles after wr_en; read DISP returns same.
- kp_value 0→5 held 16 cycles (STABLE_CYCLES=16) → count 1. Glitch 5→9 for 3 cycles then 5 → no push until 16 fresh stable cycles. Read KPDATA → 5, then STATUS empty.
- Five distinct stable values with no reads (depth 4) → STATUS full, count 4, overflow 1. KPDATA reads return first four in order; write STATUS clears overflow.
- Full FIFO, rd_en KPDATA on commit cycle → oldest returned, count stays 4, overflow 0. rd_en+wr_en together → write done, rdata_valid low.
- KP_ECHO_EN: CTRL=1, commit value −3 → disp_din 0xFFFF_FFFD. Write DISP=7 → unchanged until CTRL=0, then 7.

Source files
------------

// File: rtl/peripheral_bus_controller.sv
// peripheral_bus_controller
//
// Memory-mapped bridge between the CPU load/store port and the board
// peripherals. A keypad value must be seen unchanged for STABLE_CYCLES
// consecutive clocks before it is committed and queued in a small FIFO.
// The CPU pops that FIFO through KPDATA. A display register, or the last
// committed keypad value in echo mode, drives the display input.
//
// Optional feature macro: KP_ECHO_EN (CTRL bit0 echo mode and the
// committed->display path). When undefined, CTRL reads 0 and the display
// always follows DISP.
//
// Parameters
//   FIFO_DEPTH     keypad entry FIFO depth, power of two, 2..16
//   STABLE_CYCLES  consecutive cycles a new keypad value must hold, >= 1
// Ports
//   clk          system clock, posedge
//   rst_n        synchronous active-low reset
//   addr         register select: 0 DISP, 1 KPDATA, 2 STATUS, 3 CTRL
//   wr_en/rd_en  single-cycle write/read strobes (write wins if both)
//   wdata        write data
//   rdata        registered read data
//   rdata_valid  one-cycle pulse when rdata carries a read result
//   kp_value     signed keypad value, synchronous to clk
//   disp_din     registered signed value to the display peripheral
module peripheral_bus_controller #(
    parameter int FIFO_DEPTH    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    input  logic [31:0] kp_value,
    output logic [31:0] disp_din
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam int SCNT_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [1:0] ADDR_DISP   = 2'd0;
    localparam logic [1:0] ADDR_KPDATA = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam logic [FCNT_W-1:0] FIFO_FULL_CNT = FCNT_W'(FIFO_DEPTH);
    localparam logic [SCNT_W-1:0] STABLE_LIMIT  = SCNT_W'(STABLE_CYCLES);

    typedef enum logic {TRACK, QUALIFY} det_state_e;

    // ---------------- change detector ----------------
    det_state_e        state_q, state_d;
    logic [31:0]       committed_q, committed_d;
    logic [31:0]       candidate_q, candidate_d;
    logic [SCNT_W-1:0] count_q, count_d;
    logic [SCNT_W-1:0] count_inc;
    logic              eq_committed, eq_candidate;
    logic              commit;

    assign eq_committed = (kp_value == committed_q);
    assign eq_candidate = (kp_value == candidate_q);
    assign count_inc    = count_q + 1'b1;

    // Next-state process: decides state transitions and the commit event.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        unique case (state_q)
            TRACK: begin
                if (!eq_committed) begin
                    // A single stable cycle suffices: commit right away.
                    if (STABLE_CYCLES == 1) commit  = 1'b1;
                    else                    state_d = QUALIFY;
                end
            end
            QUALIFY: begin
                if (eq_committed) begin
                    state_d = TRACK;
                end else if (eq_candidate ? (count_inc == STABLE_LIMIT)
                                          : (STABLE_CYCLES == 1)) begin
                    commit  = 1'b1;
                    state_d = TRACK;
                end
            end
            default: state_d = TRACK;
        endcase
    end

    // Output process: candidate/count bookkeeping and the commit datapath.
    always_comb begin
        candidate_d = candidate_q;
        count_d     = count_q;
        committed_d = committed_q;
        unique case (state_q)
            TRACK: begin
                if (!eq_committed) begin
                    candidate_d = kp_value;
                    count_d     = SCNT_W'(1);
                end
            end
            QUALIFY: begin
                if (eq_committed) begin
                    count_d = '0;
                end else if (eq_candidate) begin
                    count_d = count_inc;
                end else begin
                    candidate_d = kp_value;
                    count_d     = SCNT_W'(1);
                end
            end
            default: count_d = '0;
        endcase
        if (commit) begin
            committed_d = candidate_d;
            count_d     = '0;
        end
    end

    // ---------------- entry FIFO ----------------
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [FCNT_W-1:0] fifo_cnt_q;
    logic              overflow_q;
    logic              fifo_empty, fifo_full;
    logic              rd_act, pop_req, do_pop, do_push, overflow_set;

    assign fifo_empty   = (fifo_cnt_q == '0);
    assign fifo_full    = (fifo_cnt_q == FIFO_FULL_CNT);
    assign rd_act       = rd_en && !wr_en;
    assign pop_req      = rd_act && (addr == ADDR_KPDATA);
    assign do_pop       = pop_req && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push      = commit && (!fifo_full || do_pop);
    assign overflow_set = commit && fifo_full && !do_pop;

    // ---------------- bus registers ----------------
    logic [31:0] disp_q;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic [31:0] disp_din_q, disp_din_d;
    logic [31:0] status_word;
    logic        echo_mode;

    assign status_word = {19'b0, 5'(fifo_cnt_q), 5'b0, overflow_q, fifo_full, fifo_empty};

    always_comb begin
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        if (rd_act) begin
            rdata_valid_d = 1'b1;
            unique case (addr)
                ADDR_DISP:   rdata_d = disp_q;
                ADDR_KPDATA: rdata_d = fifo_empty ? 32'b0 : mem_q[rd_ptr_q];
                ADDR_STATUS: rdata_d = status_word;
                ADDR_CTRL:   rdata_d = {31'b0, echo_mode};
                default:     rdata_d = 32'b0;
            endcase
        end
    end

`ifdef KP_ECHO_EN
    logic echo_q;
    always_ff @(posedge clk) begin
        if (!rst_n)                             echo_q <= 1'b0;
        else if (wr_en && addr == ADDR_CTRL)    echo_q <= wdata[0];
    end
    assign echo_mode  = echo_q;
    assign disp_din_d = echo_q ? committed_q : disp_q;
`else
    assign echo_mode  = 1'b0;
    assign disp_din_d = disp_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= TRACK;
            committed_q   <= '0;
            candidate_q   <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            overflow_q    <= 1'b0;
            disp_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            disp_din_q    <= '0;
        end else begin
            state_q       <= state_d;
            committed_q   <= committed_d;
            candidate_q   <= candidate_d;
            count_q       <= count_d;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            fifo_cnt_q    <= fifo_cnt_q + FCNT_W'(do_push) - FCNT_W'(do_pop);
            // A new overflow in the same cycle as a clearing write wins.
            if (overflow_set)                         overflow_q <= 1'b1;
            else if (wr_en && addr == ADDR_STATUS)    overflow_q <= 1'b0;
            if (wr_en && addr == ADDR_DISP) disp_q <= wdata;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            disp_din_q    <= disp_din_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers and count
    // define which entries are valid, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= candidate_d;
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign disp_din    = disp_din_q;

endmodule

// File: tb/tb_peripheral_bus_controller.sv
// Bench for peripheral_bus_controller: directed bus/keypad stimulus, a
// queue-based reference model checked every cycle, plus literal expectations.
module tb_peripheral_bus_controller;
    localparam int DEPTH  = 4;
    localparam int STABLE = 16;
    localparam logic [1:0] A_DISP = 2'd0, A_KP = 2'd1, A_STAT = 2'd2, A_CTRL = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  addr = '0;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] wdata = '0, kp_value = '0;
    logic [31:0] rdata, disp_din;
    logic        rdata_valid;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    peripheral_bus_controller #(.FIFO_DEPTH(DEPTH), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .kp_value(kp_value), .disp_din(disp_din)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Keypad qualification as a run length: a value commits once it has been
    // sampled STABLE times in a row while differing from the committed value.
    logic [31:0] m_q[$];
    logic        m_ovf, m_echo;
    logic [31:0] m_disp, m_comm, run_val;
    int          run_len;
    logic [31:0] e_rdata, e_disp;
    logic        e_valid;
    bit          chk_en = 0;

    function automatic logic [31:0] m_status();
        return {19'b0, 5'(m_q.size()), 5'b0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_ovf = 0; m_echo = 0; m_disp = 0; m_comm = 0;
            run_len = 0; run_val = 0;
            e_rdata = 0; e_valid = 0; e_disp = 0;
        end else begin
            e_disp  = m_echo ? m_comm : m_disp;
            e_valid = 0;
            if (rd_en && !wr_en) begin
                e_valid = 1;
                case (addr)
                    A_DISP: e_rdata = m_disp;
                    A_KP:   e_rdata = (m_q.size() != 0) ? m_q.pop_front() : 32'h0;
                    A_STAT: e_rdata = m_status();
                    default: e_rdata = {31'b0, m_echo};
                endcase
            end
            if (wr_en) begin
                if (addr == A_DISP) m_disp = wdata;
                if (addr == A_STAT) m_ovf = 0;
`ifdef KP_ECHO_EN
                if (addr == A_CTRL) m_echo = wdata[0];
`endif
            end
            if (run_len != 0 && kp_value == run_val) run_len++;
            else begin run_val = kp_value; run_len = 1; end
            if (kp_value != m_comm && run_len == STABLE) begin
                m_comm = kp_value;
                if (m_q.size() < DEPTH) m_q.push_back(kp_value);
                else m_ovf = 1;
            end
        end
        chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rdata_valid", 32'(rdata_valid), 32'(e_valid));
            check("model_disp_din", disp_din, e_disp);
            if (e_valid) check("model_rdata", rdata, e_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic expect_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check(name, rdata, exp);
        check({name, "_valid"}, 32'(rdata_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        step(2);
        check("reset_rdata", rdata, 32'h0);
        check("reset_valid", 32'(rdata_valid), 32'd0);
        check("reset_disp", disp_din, 32'h0);
        rst_n = 1'b1;

        expect_read(A_STAT, 32'h0000_0001, "status_after_reset");

        bus_write(A_DISP, 32'h7FFF_FFF0);
        check("disp_one_cycle", disp_din, 32'h0);
        step(1);
        check("disp_two_cycles", disp_din, 32'h7FFF_FFF0);
        expect_read(A_DISP, 32'h7FFF_FFF0, "read_disp");

        // Glitch during qualification restarts the stability window.
        kp_value = 32'd5; step(10);
        kp_value = 32'd9; step(3);
        kp_value = 32'd5; step(14);
        expect_read(A_STAT, 32'h0000_0001, "no_early_commit");
        step(1);
        expect_read(A_STAT, 32'h0000_0100, "status_one_entry");
        expect_read(A_KP, 32'd5, "kpdata_5");
        expect_read(A_STAT, 32'h0000_0001, "status_empty_again");

        // Five commits into a depth-4 FIFO: overflow.
        for (int v = 11; v <= 15; v++) begin
            kp_value = 32'(v); step(STABLE);
        end
        expect_read(A_STAT, 32'h0000_0406, "status_full_ovf");
        for (int v = 11; v <= 14; v++) expect_read(A_KP, 32'(v), "kpdata_order");
        expect_read(A_STAT, 32'h0000_0005, "ovf_sticky");
        bus_write(A_STAT, 32'h0);
        expect_read(A_STAT, 32'h0000_0001, "ovf_cleared");

        // Pop on the commit cycle while full.
        for (int v = 21; v <= 24; v++) begin
            kp_value = 32'(v); step(STABLE);
        end
        expect_read(A_STAT, 32'h0000_0402, "status_full");
        kp_value = 32'd25; step(STABLE - 1);
        expect_read(A_KP, 32'd21, "pop_on_commit");
        expect_read(A_STAT, 32'h0000_0402, "full_no_ovf");
        for (int v = 22; v <= 25; v++) expect_read(A_KP, 32'(v), "kpdata_after_swap");

        // Read and write together: write wins, no read pulse.
        addr = A_DISP; wdata = 32'h0000_1234; wr_en = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdwr_no_valid", 32'(rdata_valid), 32'd0);
        expect_read(A_DISP, 32'h0000_1234, "rdwr_write_done");

        // Pop while empty, then pop-empty coinciding with a push.
        expect_read(A_KP, 32'h0, "pop_empty");
        kp_value = 32'd30; step(STABLE - 1);
        expect_read(A_KP, 32'h0, "pop_empty_with_push");
        expect_read(A_STAT, 32'h0000_0100, "push_kept");
        expect_read(A_KP, 32'd30, "kpdata_30");

`ifdef KP_ECHO_EN
        bus_write(A_CTRL, 32'h1);
        expect_read(A_CTRL, 32'h1, "ctrl_echo_on");
        kp_value = 32'hFFFF_FFFD; step(STABLE);
        step(1);
        check("echo_minus3", disp_din, 32'hFFFF_FFFD);
        bus_write(A_DISP, 32'd7);
        step(3);
        check("echo_hides_disp", disp_din, 32'hFFFF_FFFD);
        bus_write(A_CTRL, 32'h0);
        step(1);
        check("echo_off_disp", disp_din, 32'd7);
`else
        bus_write(A_CTRL, 32'h1);
        expect_read(A_CTRL, 32'h0, "ctrl_reads_zero");
        step(1);
        check("no_echo_disp", disp_din, 32'h0000_1234);
`endif

        // Reset in the middle of qualification discards the candidate.
        kp_value = 32'd40; step(5);
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        check("midreset_disp", disp_din, 32'h0);
        step(14);
        expect_read(A_STAT, 32'h0000_0001, "midreset_restart");
        step(1);
        expect_read(A_STAT, 32'h0000_0100, "midreset_commit");

        // A keypad value of 0 after reset is never pushed.
        rst_n = 1'b0; kp_value = 32'd0; step(1); rst_n = 1'b1;
        step(20);
        expect_read(A_STAT, 32'h0000_0001, "zero_not_pushed");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
